// File: rtl/bids22_host_seq.sv
// bids22_host_seq: host-side command sequencer for the bids22 auction controller.
// Takes one round config, programs the controller, runs the round, unlocks it and reports one result.
module bids22_host_seq #(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 16,
    parameter int RES_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DATA_W-1:0] cfg_x_value,
    input  logic [DATA_W-1:0] cfg_y_value,
    input  logic [DATA_W-1:0] cfg_z_value,
    input  logic [2:0]        cfg_mask,
    input  logic [DATA_W-1:0] cfg_timer,
    input  logic [DATA_W-1:0] cfg_bid_cost,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic [LEN_W-1:0]  cfg_round_len,
    output logic [3:0]        C_op,
    output logic [DATA_W-1:0] C_data,
    output logic              C_start,
    input  logic              ready,
    input  logic [2:0]        err,
    input  logic              roundOver,
    input  logic [DATA_W-1:0] maxBid,
    input  logic              X_win,
    input  logic              Y_win,
    input  logic              Z_win,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_max_bid,
    output logic [2:0]        res_winner,
    output logic [2:0]        res_err,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, CFG, ROUND, WAIT_RES, UNLOCK, DONE} state_t;
    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_UNLOCK = 4'd1;
    localparam logic [3:0] OP_LOCK   = 4'd2;
    localparam logic [3:0] OP_LOADX  = 4'd3;
    state_t state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [DATA_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d, timer_q, timer_d, cost_q, cost_d, key_q, key_d;
    logic [2:0] mask_q, mask_d;
    logic [DATA_W-1:0] cap_max_q, cap_max_d;
    logic [2:0] cap_win_q, cap_win_d, cap_err_q, cap_err_d;
    logic [3:0] c_op_q, c_op_d;
    logic [DATA_W-1:0] c_data_q, c_data_d;
    logic c_start_q, c_start_d;
    logic res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic [2:0] res_win_q, res_win_d, res_err_q, res_err_d;
    logic [2:0] step;
    logic [3:0] step_op;
    logic [DATA_W-1:0] step_data;

    assign cfg_ready   = reset_n && ready && state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign C_op        = c_op_q;
    assign C_data      = c_data_q;
    assign C_start     = c_start_q;
    assign res_valid   = res_valid_q;
    assign res_max_bid = res_max_q;
    assign res_winner  = res_win_q;
    assign res_err     = res_err_q;

    // Saturating shared counter and the op/operand of the next configuration step.
    always_comb begin
        cnt_inc   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        step      = cnt_q[2:0] + 3'd1;
        step_op   = step == 3'd6 ? OP_LOCK : OP_LOADX + {1'b0, step};
        step_data = step == 3'd1 ? y_q :
                    step == 3'd2 ? z_q :
                    step == 3'd3 ? DATA_W'(mask_q) :
                    step == 3'd4 ? timer_q :
                    step == 3'd5 ? cost_q : key_q;
    end

    // Sequencer next-state: programming, round timing, result capture and abort on controller reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        mask_d      = mask_q;
        timer_d     = timer_q;
        cost_d      = cost_q;
        key_d       = key_q;
        cap_max_d   = cap_max_q;
        cap_win_d   = cap_win_q;
        cap_err_d   = cap_err_q;
        c_op_d      = OP_NOP;
        c_data_d    = '0;
        c_start_d   = 1'b0;
        res_valid_d = 1'b0;
        res_max_d   = res_max_q;
        res_win_d   = res_win_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: if (cfg_valid && cfg_ready) begin
                x_d      = cfg_x_value;
                y_d      = cfg_y_value;
                z_d      = cfg_z_value;
                mask_d   = cfg_mask;
                timer_d  = cfg_timer;
                cost_d   = cfg_bid_cost;
                key_d    = cfg_key;
                len_d    = cfg_round_len == '0 ? LEN_W'(1) : cfg_round_len;
                cnt_d    = '0;
                c_op_d   = OP_LOADX;
                c_data_d = cfg_x_value;
                state_d  = CFG;
            end
            CFG: if (err != 3'b0) begin
                res_valid_d = 1'b1;
                res_err_d   = err;
                res_win_d   = 3'b0;
                res_max_d   = '0;
                state_d     = DONE;
            end else if (cnt_q[2:0] == 3'd6) begin
                c_start_d = 1'b1;
                cnt_d     = LEN_W'(1);
                state_d   = ROUND;
            end else begin
                c_op_d   = step_op;
                c_data_d = step_data;
                cnt_d    = cnt_inc;
            end
            ROUND: if (cnt_q >= len_q) begin
                cnt_d   = '0;
                state_d = WAIT_RES;
            end else begin
                c_start_d = 1'b1;
                cnt_d     = cnt_inc;
            end
            WAIT_RES: if (roundOver || cnt_q >= LEN_W'(RES_TIMEOUT - 1)) begin
                cap_max_d = roundOver ? maxBid : '0;
                cap_win_d = roundOver ? {Z_win, Y_win, X_win} : 3'b0;
                cap_err_d = roundOver ? err : 3'b111;
                c_op_d    = OP_UNLOCK;
                c_data_d  = key_q;
                state_d   = UNLOCK;
            end else begin
                cnt_d = cnt_inc;
            end
            UNLOCK: begin
                res_valid_d = 1'b1;
                res_max_d   = cap_max_q;
                res_win_d   = cap_win_q;
                res_err_d   = cap_err_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !ready) begin
            state_d     = IDLE;
            c_op_d      = OP_NOP;
            c_data_d    = '0;
            c_start_d   = 1'b0;
            res_valid_d = 1'b0;
            res_max_d   = res_max_q;
            res_win_d   = res_win_q;
            res_err_d   = res_err_q;
        end
    end

    // State, latched config, captures and registered controller/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mask_q      <= '0;
            timer_q     <= '0;
            cost_q      <= '0;
            key_q       <= '0;
            cap_max_q   <= '0;
            cap_win_q   <= '0;
            cap_err_q   <= '0;
            c_op_q      <= OP_NOP;
            c_data_q    <= '0;
            c_start_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_max_q   <= '0;
            res_win_q   <= '0;
            res_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            cost_q      <= cost_d;
            key_q       <= key_d;
            cap_max_q   <= cap_max_d;
            cap_win_q   <= cap_win_d;
            cap_err_q   <= cap_err_d;
            c_op_q      <= c_op_d;
            c_data_q    <= c_data_d;
            c_start_q   <= c_start_d;
            res_valid_q <= res_valid_d;
            res_max_q   <= res_max_d;
            res_win_q   <= res_win_d;
            res_err_q   <= res_err_d;
        end
    end
endmodule

// File: tb/tb_bids22_host_seq.sv
// tb_bids22_host_seq: per-cycle trace check of bids22_host_seq against an expected round trace.
module tb_bids22_host_seq;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int RT = 8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] data;
        logic        st;
        logic        rv;
        logic        bz;
        logic        cr;
    } cyc_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready;
    logic [DW-1:0] cfg_x_value = '0, cfg_y_value = '0, cfg_z_value = '0;
    logic [2:0] cfg_mask = '0;
    logic [DW-1:0] cfg_timer = '0, cfg_bid_cost = '0, cfg_key = '0;
    logic [LW-1:0] cfg_round_len = '0;
    logic [3:0] C_op;
    logic [DW-1:0] C_data;
    logic C_start;
    logic ready = 1'b0;
    logic [2:0] err;
    logic roundOver = 1'b0;
    logic [DW-1:0] maxBid = '0;
    logic X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
    logic res_valid;
    logic [DW-1:0] res_max_bid;
    logic [2:0] res_winner, res_err;
    logic busy;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] err_op = '0;
    logic [2:0] err_code = '0, ro_err = '0;
    int e_at, ro_d;
    logic [2:0] ec, rerr, win;

    always #5 clk = ~clk;

    // Controller model: err reacts combinationally to the chosen op, or accompanies roundOver.
    assign err = (err_op != 4'd0 && C_op == err_op) ? err_code : (roundOver ? ro_err : 3'b0);

    bids22_host_seq #(.DATA_W(DW), .LEN_W(LW), .RES_TIMEOUT(RT)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_x_value(cfg_x_value), .cfg_y_value(cfg_y_value), .cfg_z_value(cfg_z_value),
        .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_bid_cost(cfg_bid_cost),
        .cfg_key(cfg_key), .cfg_round_len(cfg_round_len), .C_op(C_op), .C_data(C_data),
        .C_start(C_start), .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .res_valid(res_valid),
        .res_max_bid(res_max_bid), .res_winner(res_winner), .res_err(res_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic cyc_t mk(input logic [3:0] op, input logic [31:0] data,
                                input logic st, input logic rv, input logic bz, input logic cr);
        mk.op = op; mk.data = data; mk.st = st; mk.rv = rv; mk.bz = bz; mk.cr = cr;
    endfunction

    // Builds the expected cycle-by-cycle trace of one round from its config and scenario, then drives and checks it.
    task automatic run_round(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input logic [31:0] tm, input logic [31:0] cost, input logic [31:0] key,
                             input logic [2:0] mask, input logic [15:0] len, input int err_at,
                             input logic [2:0] ecode, input int rod, input logic [31:0] mb,
                             input logic [2:0] w, input logic [2:0] re, input bit noise);
        logic [3:0] ops [7];
        logic [31:0] dat [7];
        cyc_t tr[$];
        int l, ro_idx;
        logic [31:0] exp_mb;
        logic [2:0] exp_win, exp_err;
        ops = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
        dat = '{x, y, z, {29'b0, mask}, tm, cost, key};
        l = (len == 16'd0) ? 1 : int'(len);
        ro_idx = -1;
        tr.push_back(mk(4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < ((err_at != 0) ? err_at : 7); k++)
            tr.push_back(mk(ops[k], dat[k], 1'b0, 1'b0, 1'b1, 1'b0));
        if (err_at != 0) begin
            exp_mb = 32'd0; exp_win = 3'b000; exp_err = ecode;
        end else begin
            for (int k = 0; k < l; k++) tr.push_back(mk(4'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0));
            for (int k = 0; k < ((rod < 0) ? RT : rod + 1); k++)
                tr.push_back(mk(4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
            tr.push_back(mk(4'd1, key, 1'b0, 1'b0, 1'b1, 1'b0));
            if (rod >= 0) ro_idx = 8 + l + rod;
            exp_mb  = (rod < 0) ? 32'd0 : mb;
            exp_win = (rod < 0) ? 3'b000 : w;
            exp_err = (rod < 0) ? 3'b111 : re;
        end
        tr.push_back(mk(4'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        tr.push_back(mk(4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        err_op   = (err_at != 0) ? ops[err_at - 1] : 4'd0;
        err_code = ecode;
        ro_err   = re;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            chk($sformatf("c_op@%0d", i), C_op, tr[i].op);
            chk($sformatf("c_data@%0d", i), C_data, tr[i].data);
            chk($sformatf("c_start@%0d", i), C_start, tr[i].st);
            chk($sformatf("res_valid@%0d", i), res_valid, tr[i].rv);
            chk($sformatf("busy@%0d", i), busy, tr[i].bz);
            chk($sformatf("cfg_ready@%0d", i), cfg_ready, tr[i].cr);
            if (tr[i].rv || i == tr.size() - 1) begin
                chk($sformatf("res_err@%0d", i), res_err, exp_err);
                chk($sformatf("res_winner@%0d", i), res_winner, exp_win);
                if (err_at == 0) chk($sformatf("res_max_bid@%0d", i), res_max_bid, exp_mb);
            end
            cfg_valid = (i == 0) || (noise && i < tr.size() - 1 && $urandom_range(1, 0) == 1);
            if (i == 0) begin
                cfg_x_value = x; cfg_y_value = y; cfg_z_value = z; cfg_mask = mask;
                cfg_timer = tm; cfg_bid_cost = cost; cfg_key = key; cfg_round_len = len;
            end else if (noise) begin
                cfg_x_value = $urandom; cfg_y_value = $urandom; cfg_z_value = $urandom;
                cfg_mask = 3'($urandom); cfg_timer = $urandom; cfg_bid_cost = $urandom;
                cfg_key = $urandom; cfg_round_len = 16'($urandom);
            end
            roundOver = (i == ro_idx);
            maxBid = roundOver ? mb : $urandom;
            {Z_win, Y_win, X_win} = roundOver ? w : 3'($urandom);
        end
        err_op = '0;
    endtask

    // Accepts a long round and stops partway through its C_start window.
    task automatic start_long();
        @(negedge clk);
        cfg_valid = 1'b1; cfg_round_len = 16'd10; cfg_key = 32'h1234;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_c_op", C_op, 4'd0);
        chk("rst_c_data", C_data, 32'd0);
        chk("rst_c_start", C_start, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_err", res_err, 3'b0);
        chk("rst_res_max", res_max_bid, 32'd0);
        reset_n = 1'b1;
        #1 chk("post_rst_cfg_ready", cfg_ready, 1'b1);
        run_round(32'd100, 32'd100, 32'd100, 32'd5, 32'd1, 32'hA5, 3'd7, 16'd4, 0, 3'd0, 2, 32'd40, 3'b010, 3'b000, 1'b0);
        run_round(32'd100, 32'd100, 32'd100, 32'd5, 32'd1, 32'hA5, 3'd7, 16'd4, 0, 3'd0, 0, 32'd20, 3'b000, 3'b101, 1'b0);
        run_round(32'd7, 32'd8, 32'd9, 32'd3, 32'd2, 32'h5A, 3'd5, 16'd3, 0, 3'd0, -1, 32'd77, 3'b001, 3'b000, 1'b0);
        run_round(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'h66, 3'd3, 16'd0, 0, 3'd0, 1, 32'd9, 3'b100, 3'b000, 1'b1);
        run_round(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'h66, 3'd3, 16'd2, 4, 3'd6, 1, 32'd9, 3'b100, 3'b000, 1'b0);
        repeat (40) begin
            e_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
            ro_d = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(7, 0));
            ec   = 3'($urandom_range(7, 1));
            rerr = ($urandom_range(1, 0) == 1) ? 3'b101 : 3'b000;
            win  = (rerr != 3'b0) ? 3'b000 : 3'($urandom);
            run_round($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 3'($urandom),
                      16'($urandom_range(6, 0)), e_at, ec, ro_d, $urandom, win, rerr, 1'b1);
        end
        start_long();
        chk("abort_pre_start", C_start, 1'b1);
        ready = 1'b0;
        @(negedge clk);
        chk("abort_c_start", C_start, 1'b0);
        chk("abort_c_op", C_op, 4'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_res_valid", res_valid, 1'b0);
        chk("abort_cfg_ready", cfg_ready, 1'b0);
        ready = 1'b1;
        #1 chk("abort_cfg_ready_back", cfg_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_result", res_valid, 1'b0);
        end
        start_long();
        chk("rst_mid_pre_start", C_start, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_c_start", C_start, 1'b0);
        chk("rst_mid_c_op", C_op, 4'd0);
        chk("rst_mid_res_valid", res_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_cfg_ready", cfg_ready, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_cfg_ready_hi", cfg_ready, 1'b1);
        ready = 1'b0;
        #1 chk("rel_cfg_ready_lo", cfg_ready, 1'b0);
        ready = 1'b1;
        run_round(32'd11, 32'd22, 32'd33, 32'd44, 32'd55, 32'hBEEF, 3'd6, 16'd5, 0, 3'd0, 3, 32'd123, 3'b100, 3'b000, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
